// File: rtl/mor1kx_tlb_reload_master.sv
// mor1kx_tlb_reload_master: shared single-word bus read master for DMMU/IMMU TLB reload walks
// Grant locks to one MMU for its whole walk; bus error and timeout return 0 (page fault).
module mor1kx_tlb_reload_master #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    output logic                            bus_err_o,
    output logic                            busy_o
);
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;

    logic [1:0]    state;
    logic          lock, owner, last;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          own_req, keep, pick_i, gnt, gnt_own, tmo, done;
    logic [W-1:0]  gnt_addr, rdata;
    logic          unused_addr_lsb;

    assign wbm_stb_o       = wbm_cyc_o;
    assign wbm_we_o        = 1'b0;
    assign wbm_sel_o       = 4'hf;
    assign unused_addr_lsb = ^{dmmu_addr_i[1:0], immu_addr_i[1:0]};

    // owner/last: 0 = DMMU, 1 = IMMU
    always_comb begin
        own_req  = owner ? immu_req_i : dmmu_req_i;
        keep     = lock & own_req;
        pick_i   = immu_req_i & (~dmmu_req_i | ~last);
        gnt      = (state == IDLE) & (keep | dmmu_req_i | immu_req_i);
        gnt_own  = keep ? owner : pick_i;
        gnt_addr = gnt_own ? immu_addr_i : dmmu_addr_i;
        cnt_nxt  = cnt + 1'b1;
        tmo      = (TIMEOUT_CYCLES != 0) && (cnt_nxt == CW'(TIMEOUT_CYCLES));
        done     = (state == BUS) & (wbm_ack_i | wbm_err_i | tmo);
        rdata    = wbm_ack_i ? wbm_dat_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lock        <= 1'b0;
            owner       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            wbm_adr_o   <= '0;
            wbm_cyc_o   <= 1'b0;
            dmmu_ack_o  <= 1'b0;
            immu_ack_o  <= 1'b0;
            dmmu_data_o <= '0;
            immu_data_o <= '0;
            bus_err_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            dmmu_ack_o <= 1'b0;
            immu_ack_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (state == IDLE) begin
                // no grant means nobody requests, so the lock always falls here
                lock   <= gnt;
                busy_o <= gnt;
                if (gnt) begin
                    state     <= BUS;
                    owner     <= gnt_own;
                    last      <= gnt_own;
                    wbm_adr_o <= {gnt_addr[W-1:2], 2'b00};
                    wbm_cyc_o <= 1'b1;
                    cnt       <= '0;
                end
            end else if (state == BUS) begin
                cnt <= cnt_nxt;
                if (done) begin
                    state     <= RESP;
                    wbm_cyc_o <= 1'b0;
                    bus_err_o <= ~wbm_ack_i;
                    // an MMU that dropped req mid-cycle gets no ack
                    dmmu_ack_o <= ~owner & dmmu_req_i;
                    immu_ack_o <= owner & immu_req_i;
                    if (~owner & dmmu_req_i)
                        dmmu_data_o <= rdata;
                    if (owner & immu_req_i)
                        immu_data_o <= rdata;
                end
            end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mor1kx_tlb_reload_master.sv
// tb_mor1kx_tlb_reload_master: directed vector table plus hand sequences for timeout, abort and reset
module tb_mor1kx_tlb_reload_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dreq = 1'b0, ireq = 1'b0;
    logic [31:0] da = '0, ia = '0;
    logic        dack, iack;
    logic [31:0] ddata, idata, adr;
    logic        cyc, stb, we, berr, busy;
    logic [3:0]  sel;
    logic [31:0] wdat = '0;
    logic        wack = 1'b0, werr = 1'b0;
    int          n_chk = 0, n_fail = 0;

    localparam logic [31:0] A1 = 32'h0000_1003, E1 = 32'h0000_1000;
    localparam logic [31:0] A2 = 32'h0040_2C0E, E2 = 32'h0040_2C0C;
    localparam logic [31:0] I1 = 32'h0000_8006, EI = 32'h0000_8004;
    localparam logic [31:0] D1 = 32'h0040_2000, D2 = 32'h1234_E4C7;
    localparam logic [31:0] DI = 32'hCAFE_0001, DJ = 32'h1111_1111, DK = 32'h5555_AAAA;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    mor1kx_tlb_reload_master #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmmu_req_i(dreq), .dmmu_addr_i(da), .dmmu_ack_o(dack), .dmmu_data_o(ddata),
        .immu_req_i(ireq), .immu_addr_i(ia), .immu_ack_o(iack), .immu_data_o(idata),
        .wbm_adr_o(adr), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_dat_i(wdat), .wbm_ack_i(wack), .wbm_err_i(werr),
        .bus_err_o(berr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, dreq;
        logic [31:0] da;
        logic        ireq;
        logic [31:0] ia;
        logic        ack, err;
        logic [31:0] dat;
        logic        cyc;
        logic [31:0] adr;
        logic        dack;
        logic [31:0] dd;
        logic        iack;
        logic [31:0] id;
        logic        berr, busy;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(logic r, logic dr, logic [31:0] a, logic ir, logic [31:0] b,
                                logic k, logic e, logic [31:0] d, logic c, logic [31:0] ad,
                                logic dk, logic [31:0] dd, logic ik, logic [31:0] id,
                                logic be, logic bz);
        vec_t v;
        v.rst = r; v.dreq = dr; v.da = a; v.ireq = ir; v.ia = b; v.ack = k; v.err = e; v.dat = d;
        v.cyc = c; v.adr = ad; v.dack = dk; v.dd = dd; v.iack = ik; v.id = id; v.berr = be; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // DMMU-only two-level walk, ack on the second bus cycle
        q.push_back(mk(0,1,A1,0,0, 0,0,0,   1,E1,0,0,0,0,0,1));
        q.push_back(mk(0,1,A1,0,0, 0,0,0,   1,E1,0,0,0,0,0,1));
        q.push_back(mk(0,1,A1,0,0, 1,0,D1,  0,0,1,D1,0,0,0,1));
        q.push_back(mk(0,1,A1,0,0, 0,0,0,   0,0,0,D1,0,0,0,0));
        q.push_back(mk(0,1,A2,0,0, 0,0,0,   1,E2,0,D1,0,0,0,1));
        q.push_back(mk(0,1,A2,0,0, 0,0,0,   1,E2,0,D1,0,0,0,1));
        q.push_back(mk(0,1,A2,0,0, 1,0,D2,  0,0,1,D2,0,0,0,1));
        q.push_back(mk(0,1,A2,0,0, 0,0,0,   0,0,0,D2,0,0,0,0));
        q.push_back(mk(0,0,0,0,0,  0,0,0,   0,0,0,D2,0,0,0,0));
        // reset, then both request together: DMMU holds the lock over both levels
        q.push_back(mk(1,0,0,0,0,  0,0,0,   0,0,0,0,0,0,0,0));
        q.push_back(mk(0,1,A1,1,I1, 0,0,0,  1,E1,0,0,0,0,0,1));
        q.push_back(mk(0,1,A1,1,I1, 0,0,0,  1,E1,0,0,0,0,0,1));
        q.push_back(mk(0,1,A1,1,I1, 1,0,D1, 0,0,1,D1,0,0,0,1));
        q.push_back(mk(0,1,A1,1,I1, 0,0,0,  0,0,0,D1,0,0,0,0));
        q.push_back(mk(0,1,A2,1,I1, 0,0,0,  1,E2,0,D1,0,0,0,1));
        q.push_back(mk(0,1,A2,1,I1, 1,0,D2, 0,0,1,D2,0,0,0,1));
        q.push_back(mk(0,1,A2,1,I1, 0,0,0,  0,0,0,D2,0,0,0,0));
        q.push_back(mk(0,0,0,1,I1,  0,0,0,  1,EI,0,D2,0,0,0,1));
        q.push_back(mk(0,0,0,1,I1,  1,0,DI, 0,0,0,D2,1,DI,0,1));
        q.push_back(mk(0,0,0,1,I1,  0,0,0,  0,0,0,D2,0,DI,0,0));
        q.push_back(mk(0,0,0,0,0,   0,0,0,  0,0,0,D2,0,DI,0,0));
        // bus error on DMMU level 1, then waiting IMMU; ack beats err
        q.push_back(mk(0,1,A1,1,I1, 0,0,0,   1,E1,0,D2,0,DI,0,1));
        q.push_back(mk(0,1,A1,1,I1, 0,1,BAD, 0,0,1,0,0,DI,1,1));
        q.push_back(mk(0,1,A1,1,I1, 0,0,0,   0,0,0,0,0,DI,0,0));
        q.push_back(mk(0,0,0,1,I1,  0,0,0,   1,EI,0,0,0,DI,0,1));
        q.push_back(mk(0,0,0,1,I1,  1,1,DJ,  0,0,0,0,1,DJ,0,1));
        q.push_back(mk(0,0,0,1,I1,  0,0,0,   0,0,0,0,0,DJ,0,0));
        q.push_back(mk(0,1,A2,0,0,  0,0,0,   1,E2,0,0,0,DJ,0,1));
        q.push_back(mk(0,1,A2,0,0,  1,0,DK,  0,0,1,DK,0,DJ,0,1));
        q.push_back(mk(0,1,A2,0,0,  0,0,0,   0,0,0,DK,0,DJ,0,0));
        q.push_back(mk(0,0,0,0,0,   0,0,0,   0,0,0,DK,0,DJ,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst cyc", cyc, 0); chk("rst stb", stb, 0); chk("rst we", we, 0);
        chk("rst sel", sel, 4'hf); chk("rst adr", adr, 0); chk("rst dack", dack, 0);
        chk("rst iack", iack, 0); chk("rst ddata", ddata, 0); chk("rst idata", idata, 0);
        chk("rst berr", berr, 0); chk("rst busy", busy, 0);
        rst_n = 1'b1;

        for (int k = 0; k < q.size(); k++) begin
            rst_n = !q[k].rst; dreq = q[k].dreq; da = q[k].da; ireq = q[k].ireq; ia = q[k].ia;
            wack = q[k].ack; werr = q[k].err; wdat = q[k].dat;
            step;
            chk($sformatf("v%0d cyc", k), cyc, q[k].cyc);
            chk($sformatf("v%0d stb", k), stb, q[k].cyc);
            if (q[k].cyc) chk($sformatf("v%0d adr", k), adr, q[k].adr);
            chk($sformatf("v%0d dack", k), dack, q[k].dack);
            chk($sformatf("v%0d ddata", k), ddata, q[k].dd);
            chk($sformatf("v%0d iack", k), iack, q[k].iack);
            chk($sformatf("v%0d idata", k), idata, q[k].id);
            chk($sformatf("v%0d berr", k), berr, q[k].berr);
            chk($sformatf("v%0d busy", k), busy, q[k].busy);
        end
        rst_n = 1'b1; wack = 0; werr = 0;

        // timeout: cyc high for exactly 8 bus cycles
        dreq = 1; da = A1; ireq = 0; wdat = BAD;
        step;
        chk("to cyc1", cyc, 1);
        for (int c = 2; c <= 8; c++) begin
            step;
            chk($sformatf("to cyc%0d", c), cyc, 1);
            chk($sformatf("to dack%0d", c), dack, 0);
        end
        step;
        chk("to drop", cyc, 0); chk("to dack", dack, 1); chk("to ddata", ddata, 0);
        chk("to berr", berr, 1); chk("to busy", busy, 1);
        dreq = 0;
        step;
        chk("to idle", busy, 0); chk("to berr end", berr, 0); chk("to dack end", dack, 0);

        // MMU abort mid-bus: cycle completes, no ack, then clean re-request
        dreq = 1; da = A1;
        step;
        chk("ab cyc", cyc, 1);
        dreq = 0;
        step;
        chk("ab hold", cyc, 1); chk("ab adr", adr, E1);
        wack = 1; wdat = D1;
        step;
        chk("ab cyc0", cyc, 0); chk("ab dack", dack, 0); chk("ab berr", berr, 0);
        chk("ab busy", busy, 1); chk("ab ddata", ddata, 0);
        wack = 0;
        step;
        chk("ab idle", busy, 0);
        dreq = 1; da = A2;
        step;
        chk("ab re cyc", cyc, 1); chk("ab re adr", adr, E2);
        wack = 1; wdat = D2;
        step;
        chk("ab re dack", dack, 1); chk("ab re ddata", ddata, D2);
        wack = 0;
        step;
        dreq = 0;
        step;
        chk("ab end busy", busy, 0);

        // both request, DMMU served last -> IMMU; then async reset mid-bus
        dreq = 1; da = A1; ireq = 1; ia = I1;
        step;
        chk("rr cyc", cyc, 1); chk("rr adr", adr, EI);
        #2 rst_n = 0;
        #1;
        chk("ar cyc", cyc, 0); chk("ar stb", stb, 0); chk("ar busy", busy, 0);
        wack = 1; wdat = DI;
        step;
        chk("ar iack", iack, 0); chk("ar dack", dack, 0); chk("ar idata", idata, 0);
        wack = 0; rst_n = 1;
        step;
        chk("ar rel cyc", cyc, 1); chk("ar rel adr", adr, E1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
